// File: rtl/sp_bram_stream_reader.sv
// Single-port BRAM burst reader: turns a base/length command into SP reads and
// re-times the returned words through a small FIFO onto a valid/ready stream.
module sp_bram_stream_reader #(
   parameter int BIT_WIDTH    = 16,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 start,
   input  logic [13:0]          base_addr,
   input  logic [14:0]          length,
   output logic                 busy,
   output logic                 done,
   output logic                 ram_ce,
   output logic                 ram_oce,
   output logic                 ram_wre,
   output logic [13:0]          ram_ad,
   input  logic [BIT_WIDTH-1:0] ram_do,
   output logic [BIT_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [14:0]           len_q, len_d;
   logic [14:0]           issued_q, issued_d;
   logic [14:0]           beats_q, beats_d;
   logic [13:0]           ad_next_q, ad_next_d;
   logic [13:0]           ram_ad_q, ram_ad_d;
   logic                  ram_ce_q, ram_ce_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [READ_LATENCY:0] pipe_q, pipe_d;
   logic [BIT_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
   logic [BIT_WIDTH-1:0]  fifo_d [FIFO_DEPTH];
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [PW:0]           count_q, count_d;

   logic                  push, pop, issue;
   logic [7:0]            inflight, occ;

   assign m_valid = (count_q != '0);
   assign m_data  = fifo_q[rptr_q];
   assign m_last  = m_valid && (beats_q == len_q - 15'd1);
   assign busy    = busy_q;
   assign done    = done_q;
   assign ram_ce  = ram_ce_q;
   assign ram_oce = ram_ce_q;
   assign ram_wre = 1'b0;
   assign ram_ad  = ram_ad_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issued_d  = issued_q;
      beats_d   = beats_q;
      ad_next_d = ad_next_q;
      ram_ad_d  = ram_ad_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      fifo_d    = fifo_q;

      push = pipe_q[READ_LATENCY];
      pop  = m_valid && m_ready;

      // Every issued read still owed to the FIFO holds a credit; the slot
      // freed by this cycle's pop may be reused by this cycle's issue.
      inflight = '0;
      for (int i = 0; i <= READ_LATENCY; i++) inflight = inflight + 8'(pipe_q[i]);
      occ   = 8'(count_q) + inflight - 8'(pop);
      issue = (state_q == S_RUN) && (issued_q != len_q) && (occ < 8'(FIFO_DEPTH));

      pipe_d[0] = issue;
      for (int i = 1; i <= READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

      if (issue) begin
         ram_ad_d  = ad_next_q;
         ad_next_d = ad_next_q + 14'd1;
         issued_d  = issued_q + 15'd1;
      end

      if (push) begin
         fifo_d[wptr_q] = ram_do;
         wptr_d         = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d  = rptr_q + PW'(1);
         beats_d = beats_q + 15'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ad_next_d = base_addr;
               len_d     = length;
               issued_d  = '0;
               beats_d   = '0;
               state_d   = (length == 15'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN:   if (issue && (issued_q == len_q - 15'd1)) state_d = S_DRAIN;
         S_DRAIN: if (pop && (beats_q == len_q - 15'd1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d   = (state_d == S_DONE);
      ram_ce_d = busy_d;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         issued_q  <= '0;
         beats_q   <= '0;
         ad_next_q <= '0;
         ram_ad_q  <= '0;
         ram_ce_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pipe_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         issued_q  <= issued_d;
         beats_q   <= beats_d;
         ad_next_q <= ad_next_d;
         ram_ad_q  <= ram_ad_d;
         ram_ce_q  <= ram_ce_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pipe_q    <= pipe_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      end
   end

endmodule
